// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipeline's memory-side blocks.
package riscv_pkg;

  localparam int SB_DEPTH = 4;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: wrapping head/tail pointers, occupancy count, entry storage.
// Exposes every entry plus the head as it will look after this edge.
module store_buffer_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  parameter  int XLEN  = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [XLEN-1:0]                 push_addr,
  input  logic [XLEN-1:0]                 push_data,
  output logic [PTR_W:0]                  count,
  output logic [PTR_W-1:0]                head_ptr,
  output logic [DEPTH-1:0][XLEN-1:0]      ent_addr,
  output logic [DEPTH-1:0][XLEN-1:0]      ent_data,
  output logic [XLEN-1:0]                 nxt_addr,
  output logic [XLEN-1:0]                 nxt_data
);

  logic [PTR_W-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]                   count_q, count_d;
  logic [DEPTH-1:0][XLEN-1:0]       addr_q, addr_d, data_q, data_d;

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    addr_d = addr_q;
    data_d = data_q;
    if (push) begin
      addr_d[tail_q] = push_addr;
      data_d[tail_q] = push_data;
    end
    // Reading the post-write array gives the new head even when it is the entry being pushed.
    nxt_addr = addr_d[head_d];
    nxt_data = data_d[head_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign count    = count_q;
  assign head_ptr = head_q;
  assign ent_addr = addr_q;
  assign ent_data = data_q;

endmodule

// File: rtl/store_buffer.sv
// M-stage store buffer: queues stores and drains them in order through a req/ack port.
// Define STORE_BUFFER_FWD_EN for store-to-load forwarding; otherwise loads stall until empty.
module store_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            MemReadM,
  output logic            StallM,
  output logic            FwdHitM,
  output logic [XLEN-1:0] FwdDataM,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  sb_state_e                   state_q, state_d;
  logic                        mem_req_q, mem_req_d;
  logic [XLEN-1:0]             mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic                        push, pop, stall;
  logic [PTR_W:0]              count;
  logic [PTR_W-1:0]            head_ptr;
  logic [DEPTH-1:0][XLEN-1:0]  ent_addr, ent_data;
  logic [XLEN-1:0]             nxt_addr, nxt_data;

  store_buffer_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (ALUResultM),
    .push_data (WriteDataM),
    .count     (count),
    .head_ptr  (head_ptr),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .nxt_addr  (nxt_addr),
    .nxt_data  (nxt_data)
  );

  // A full buffer rejects the store even if the head drains on the same edge.
  always_comb begin
`ifdef STORE_BUFFER_FWD_EN
    stall = MemWriteM & (count == FULL_CNT);
`else
    stall = (MemWriteM & (count == FULL_CNT)) | (MemReadM & (count != '0));
`endif
    push = MemWriteM & ~stall;
    pop  = (state_q == SB_REQ) & mem_ack;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SB_IDLE: if (count != '0) state_d = SB_REQ;
      SB_REQ:  if (mem_ack && count == ONE_CNT && !push) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
    mem_req_d   = (state_d == SB_REQ);
    mem_addr_d  = mem_req_d ? nxt_addr : '0;
    mem_wdata_d = mem_req_d ? nxt_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SB_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (MemReadM) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + PTR_W'(k);
        if ((PTR_W+1)'(k) < count && ent_addr[idx][XLEN-1:2] == ALUResultM[XLEN-1:2]) begin
          fwd_hit  = 1'b1;
          fwd_data = ent_data[idx];
        end
      end
    end
  end

  assign FwdHitM  = fwd_hit;
  assign FwdDataM = fwd_data;
`else
  logic fwd_unused;
  assign fwd_unused = ^{head_ptr, ent_addr, ent_data};
  assign FwdHitM    = 1'b0;
  assign FwdDataM   = '0;
`endif

  assign StallM    = stall;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
